// File: rtl/cell_test_sequencer_if.sv
// Control/status bundle between the Wishbone/LA glue, the cell bank and the
// cell test sequencer.
interface cell_test_sequencer_if #(
    parameter int NUM_CELLS = 23,
    parameter int ERR_W     = 5
);
    // Handshake: start is a one-cycle request, accepted only while busy=0 and
    // abort=0; busy rises on the edge that accepts it, and done (sticky) rises
    // with busy falling once the run completes; pass/err/first_fail_* are
    // valid while done=1. abort is a level that overrides start and any run.
    logic                 start;
    logic                 abort;
    logic [4:0]           cell_sel;
    logic [7:0]           settle;
    logic [NUM_CELLS-1:0] cell_y;
    logic [3:0]           cell_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 bad_sel;
    logic [ERR_W-1:0]     err_count;
    logic [3:0]           first_fail_vec;
    logic                 first_fail_valid;
    logic [2:0]           state_dbg;

    modport master (
        output start, abort, cell_sel, settle, cell_y,
        input  cell_in, busy, done, pass, bad_sel, err_count,
               first_fail_vec, first_fail_valid, state_dbg
    );

    modport slave (
        input  start, abort, cell_sel, settle, cell_y,
        output cell_in, busy, done, pass, bad_sel, err_count,
               first_fail_vec, first_fail_valid, state_dbg
    );
endinterface

// File: rtl/cell_test_sequencer.sv
// Exhaustive truth-table walker for the standard-cell bank: applies every input
// vector of the selected cell, samples its Y after a settle delay and checks it.
module cell_test_sequencer #(
    parameter int NUM_CELLS = 23,
    parameter int ERR_W     = 5
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    cell_test_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [4:0] NUM_SEL = 5'(NUM_CELLS);

    state_t           state_q, state_d;
    logic [4:0]       sel_q, sel_d;
    logic [7:0]       settle_q, settle_d;
    logic [3:0]       vec_q, vec_d;
    logic [3:0]       last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       cell_in_q, cell_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             bad_sel_q, bad_sel_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;

    // Highest vector index for each cell, i.e. 2^inputs - 1.
    function automatic logic [3:0] last_vec(input logic [4:0] s);
        logic [3:0] r;
        case (s)
            5'd4, 5'd5, 5'd6, 5'd7,
            5'd8, 5'd9, 5'd10, 5'd11, 5'd12: r = 4'd1;
            5'd2, 5'd13, 5'd15, 5'd17:       r = 4'd7;
            5'd3, 5'd18:                     r = 4'd15;
            default:                         r = 4'd3;
        endcase
        return r;
    endfunction

    function automatic logic golden(input logic [4:0] s, input logic [3:0] v);
        logic a, b, c, d, g;
        a = v[0];
        b = v[1];
        c = v[2];
        d = v[3];
        case (s)
            5'd0, 5'd1:                      g = a & b;
            5'd2:                            g = ~((a & b) | c);
            5'd3:                            g = ~((a & b) | (c & d));
            5'd4, 5'd5, 5'd6, 5'd7:          g = a;
            5'd8, 5'd9, 5'd10, 5'd11, 5'd12: g = ~a;
            5'd13:                           g = c ? b : a;
            5'd14:                           g = ~(a & b);
            5'd15:                           g = ~(a & b & c);
            5'd16:                           g = ~(a | b);
            5'd17:                           g = ~((a | b) & c);
            5'd18:                           g = ~((a | b) & (c | d));
            5'd19, 5'd20:                    g = a | b;
            5'd21:                           g = ~(a ^ b);
            5'd22:                           g = a ^ b;
            default:                         g = 1'b0;
        endcase
        return g;
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            settle_q  <= '0;
            vec_q     <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            cell_in_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            bad_sel_q <= 1'b0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            settle_q  <= settle_d;
            vec_q     <= vec_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            cell_in_q <= cell_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            bad_sel_q <= bad_sel_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        settle_d  = settle_q;
        vec_d     = vec_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        cell_in_d = cell_in_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        bad_sel_d = bad_sel_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    sel_d     = bus.cell_sel;
                    settle_d  = bus.settle;
                    vec_d     = '0;
                    last_d    = last_vec(bus.cell_sel);
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    if (bus.cell_sel >= NUM_SEL) begin
                        bad_sel_d = 1'b1;
                        state_d   = S_FINISH;
                    end else begin
                        bad_sel_d = 1'b0;
                        state_d   = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                cell_in_d = vec_q;
                // Counter runs down to zero, so load settle-1 (settle=0 acts as 1).
                cnt_d     = (settle_q == 8'd0) ? 8'd0 : settle_q - 8'd1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) state_d = S_SAMPLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_SAMPLE: begin
                if (bus.cell_y[sel_q] != golden(sel_q, vec_q)) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (vec_q == last_q) begin
                    state_d = S_FINISH;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    state_d = S_APPLY;
                end
            end
            S_FINISH: begin
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pass_d    = (err_q == '0) && !bad_sel_q;
                cell_in_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any transition; partial error results stay visible.
        if (bus.abort) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            cell_in_d = '0;
            done_d    = done_q;
            pass_d    = pass_q;
        end
    end

    assign bus.cell_in          = cell_in_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.bad_sel          = bad_sel_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;
    assign bus.state_dbg        = state_q;

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Directed bench for cell_test_sequencer: per-cycle scoreboard of busy/done/cell_in
// plus end-of-run result checks against an ideal (or stuck-at-0) cell bank model.
module tb_cell_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic y_zero = 1'b0;
  logic [22:0] ideal_y;
  logic a, b, c, d;

  int compared = 0;
  int failed = 0;
  logic [5:0] exp_q[$];

  cell_test_sequencer_if #(.NUM_CELLS(23), .ERR_W(5)) bus ();

  cell_test_sequencer #(.NUM_CELLS(23), .ERR_W(5)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ideal standard-cell bank
  assign {d, c, b, a} = bus.cell_in;
  always_comb begin
    ideal_y = '0;
    ideal_y[0]  = a & b;
    ideal_y[1]  = a & b;
    ideal_y[2]  = ~((a & b) | c);
    ideal_y[3]  = ~((a & b) | (c & d));
    ideal_y[4]  = a;
    ideal_y[5]  = a;
    ideal_y[6]  = a;
    ideal_y[7]  = a;
    ideal_y[8]  = ~a;
    ideal_y[9]  = ~a;
    ideal_y[10] = ~a;
    ideal_y[11] = ~a;
    ideal_y[12] = ~a;
    ideal_y[13] = c ? b : a;
    ideal_y[14] = ~(a & b);
    ideal_y[15] = ~(a & b & c);
    ideal_y[16] = ~(a | b);
    ideal_y[17] = ~((a | b) & c);
    ideal_y[18] = ~((a | b) & (c | d));
    ideal_y[19] = a | b;
    ideal_y[20] = a | b;
    ideal_y[21] = ~(a ^ b);
    ideal_y[22] = a ^ b;
  end
  assign bus.cell_y = y_zero ? 23'd0 : ideal_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic busy, input logic done,
                            input logic pass, input logic bad, input logic [4:0] err,
                            input logic ffvalid, input logic [3:0] ffv, input logic [3:0] cin);
    check({name, ".busy"}, 32'(bus.busy), 32'(busy));
    check({name, ".done"}, 32'(bus.done), 32'(done));
    check({name, ".pass"}, 32'(bus.pass), 32'(pass));
    check({name, ".bad_sel"}, 32'(bus.bad_sel), 32'(bad));
    check({name, ".err_count"}, 32'(bus.err_count), 32'(err));
    check({name, ".ff_valid"}, 32'(bus.first_fail_valid), 32'(ffvalid));
    check({name, ".ff_vec"}, 32'(bus.first_fail_vec), 32'(ffv));
    check({name, ".cell_in"}, 32'(bus.cell_in), 32'(cin));
  endtask

  // Driver + scoreboard: start a run, queue the expected {busy,done,cell_in}
  // for every cycle up to done, then pop and compare one entry per negedge.
  // restart_k pulses a second start after edge restart_k; stop_k ends early.
  task automatic run(input string name, input logic [4:0] sel, input logic [7:0] st,
                     input int n, input int restart_k, input int stop_k);
    int w;
    int k;
    logic [5:0] e;
    w = (st == 8'd0) ? 1 : int'(st);
    @(negedge clk);
    bus.cell_sel = sel;
    bus.settle = st;
    bus.start = 1'b1;
    for (int j = 0; j <= n * (w + 2); j++)
      exp_q.push_back({1'b1, 1'b0, (j == 0) ? 4'd0 : 4'((j - 1) / (w + 2))});
    exp_q.push_back({1'b0, 1'b1, 4'd0});
    k = 0;
    while (exp_q.size() > 0 && k != stop_k) begin
      @(negedge clk);
      bus.start = (k == restart_k) ? 1'b1 : 1'b0;
      if (k == 1) begin
        bus.cell_sel = 5'($urandom_range(0, 31));
        bus.settle = 8'($urandom_range(0, 255));
      end
      e = exp_q.pop_front();
      check($sformatf("%s.k%0d", name, k), {26'd0, bus.busy, bus.done, bus.cell_in}, {26'd0, e});
      k++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cell_sel = 5'd0;
    bus.settle = 8'd0;
    repeat (3) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 5'd0, 0, 4'd0, 4'd0);
    check("reset.state", 32'(bus.state_dbg), 32'd0);
    rst = 1'b0;

    // AND2X1, ideal bank, settle 4: done 25 cycles after start
    y_zero = 1'b0;
    run("and2", 5'd0, 8'd4, 4, -1, -1);
    check_outs("and2", 0, 1, 1, 0, 5'd0, 0, 4'd0, 4'd0);

    // XOR2X1 with Y stuck at 0: vectors 1 and 2 mismatch
    y_zero = 1'b1;
    run("xor2", 5'd22, 8'd1, 4, -1, -1);
    check_outs("xor2", 0, 1, 0, 0, 5'd2, 1, 4'd1, 4'd0);

    // Out-of-range select clears previous failure results
    run("badsel", 5'd23, 8'd7, 0, -1, -1);
    check_outs("badsel", 0, 1, 0, 1, 5'd0, 0, 4'd0, 4'd0);

    // AOI22X1, settle 0 treated as 1: 16 vectors, done at 49
    y_zero = 1'b0;
    run("aoi22", 5'd3, 8'd0, 16, -1, -1);
    check_outs("aoi22", 0, 1, 1, 0, 5'd0, 0, 4'd0, 4'd0);

    // INV stuck at 0, maximum settle: only vector 0 fails
    y_zero = 1'b1;
    run("inv", 5'd8, 8'd255, 2, -1, -1);
    check_outs("inv", 0, 1, 0, 0, 5'd1, 1, 4'd0, 4'd0);

    // OAI22X1: extra start during vector 5 must be ignored
    y_zero = 1'b0;
    run("oai22", 5'd18, 8'd2, 16, 22, -1);
    check_outs("oai22", 0, 1, 1, 0, 5'd0, 0, 4'd0, 4'd0);

    // OAI22X1 again, aborted while vector 7 is applied
    run("abort", 5'd18, 8'd2, 16, -1, 31);
    exp_q.delete();
    check("abort.cell_in_before", 32'(bus.cell_in), 32'd7);
    bus.abort = 1'b1;
    @(negedge clk);
    check_outs("abort", 0, 0, 0, 0, 5'd0, 0, 4'd0, 4'd0);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.idle_busy", 32'(bus.busy), 32'd0);
    check("abort.idle_state", 32'(bus.state_dbg), 32'd0);

    // start and abort together: abort wins
    bus.cell_sel = 5'd0;
    bus.settle = 8'd1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("startabort.busy", 32'(bus.busy), 32'd0);
    check("startabort.state", 32'(bus.state_dbg), 32'd0);

    // NAND3X1: reset while vector 2 is applied, then a clean rerun
    run("nand3_rst", 5'd15, 8'd3, 8, -1, 12);
    exp_q.delete();
    check("rst.cell_in_before", 32'(bus.cell_in), 32'd2);
    rst = 1'b1;
    #1;
    check_outs("midrst", 0, 0, 0, 0, 5'd0, 0, 4'd0, 4'd0);
    check("midrst.state", 32'(bus.state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("nand3", 5'd15, 8'd3, 8, -1, -1);
    check_outs("nand3", 0, 1, 1, 0, 5'd0, 0, 4'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
